piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out word serializer built on the edge-triggered storage stage.
//   Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per
//   accepted serial beat over a second valid/ready handshake.
//   Sits directly downstream of the flip-flop stage and consumes stored words.
//   Feeds bit-serial consumers such as line drivers and serial comparators.
// PARAMETERS
//   WIDTH      8   word width in bits; legal range 2..64
//   MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clock         in   1      single clock, rising-edge
//   reset         in   1      asynchronous, active-low reset
//   io_in_valid   in   1      parallel word offered
//   io_in_ready   out  1      serializer can accept a word this cycle
//   io_in_bits    in   WIDTH  parallel word
//   io_out_valid  out  1      io_out_bit is valid
//   io_out_ready  in   1      serial consumer takes io_out_bit this cycle
//   io_out_bit    out  1      current serial bit
//   io_out_last   out  1      current bit is the final bit of the word
//   io_busy       out  1      a word is being serialized
// BEHAVIOUR
//   Reset
//     - reset low clears all state asynchronously: state=IDLE, shreg=0, cnt=0.
//     - While reset is low: io_in_ready=0, io_out_valid=0, io_out_bit=0,
//       io_out_last=0, io_busy=0.
//     - io_in_ready=1 from the first cycle after reset deasserts.
//     - Reset asserted mid-word discards the word. No partial bits follow.
//   State machine (IDLE, SHIFT)
//     - IDLE: io_in_ready=1, io_out_valid=0.
//       On in_valid&in_ready: shreg<=io_in_bits, cnt<=WIDTH-1, go to SHIFT.
//     - SHIFT: io_out_valid=1, io_busy=1.
//       io_out_bit = shreg[WIDTH-1] when MSB_FIRST, else shreg[0].
//     - Serial beat = out_valid&out_ready. On a beat:
//       shift toward the output end, zero-fill, cnt<=cnt-1.
//     - No beat (out_ready=0): shreg, cnt and io_out_bit hold unchanged.
//     - io_out_last = SHIFT & (cnt==0).
//     - Beat with cnt==0: the word is complete.
//       If in_valid that cycle, load the new word and stay in SHIFT.
//       Otherwise go to IDLE.
//   Handshake rules
//     - io_in_ready = IDLE | (SHIFT & cnt==0 & io_out_ready), combinational.
//       This gives zero-bubble back-to-back words.
//     - io_out_valid never depends combinationally on io_out_ready.
//     - io_in_bits is sampled only on the accepting edge.
//     - Input changes after acceptance do not affect the word in flight.
//     - io_out_valid, once high, stays high until the final beat of the word.
//   Latency and throughput
//     - Word accepted at edge N: first bit is valid in the cycle after edge N.
//     - With io_out_ready held high: WIDTH beats per word, 100% serial occupancy.
//   Width rules
//     - cnt is $clog2(WIDTH) bits, unsigned, and never wraps below 0.
//     - cnt==0 in SHIFT always means the last bit.
//   Boundary cases
//     - A load and the last beat in the same cycle take the load.
//     - in_valid during SHIFT with cnt!=0 is ignored: ready=0, the word is held upstream.
//     - WIDTH=2: io_out_last is high on the second bit.
// STRUCTURE
//   - Shared package holds the state enum (IDLE=0, SHIFT=1).
//   - Shared package holds the function cnt_width(WIDTH)=$clog2(WIDTH).
//   - One sub-module, shift_reg_core: WIDTH-bit register with async active-low
//     clear, load and shift_en, and a MSB_FIRST direction parameter.
//   - The FSM and counter stay in the top level.
// TESTING
//   1. Reset low with in_valid=1 -> in_ready=0, out_valid=0. After release,
//      in_ready=1 next cycle.
//   2. WIDTH=8, MSB_FIRST=1, load 0xA5, out_ready=1 -> bits 1,0,1,0,0,1,0,1
//      on 8 consecutive cycles; last only on the 8th.
//   3. MSB_FIRST=0, load 0x01 -> first bit 1, then 7 zeros. Busy drops the cycle after last.
//   4. Load 0xF0, toggle out_ready 1,0,0,1... -> bit holds during stalls; exactly 8 beats.
//   5. Words 0x3C then 0xC3 with in_valid held -> second word accepted on the last beat of the first;
//      16 contiguous beats, no gap.
//   6. Assert reset after the 3rd beat of 0xFF -> outputs zero immediately. Next word 0x00
//      serializes cleanly as 8 zeros.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out word serializer.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_shift_reg_core.sv
// WIDTH-bit load/shift register. It shifts toward the output end and zero-fills.
module shift_reg_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // A load always wins over a shift in the same cycle.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_en_i) begin
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) shreg_q <= '0;
    else         shreg_q <= shreg_d;
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. It takes a WIDTH-bit word on a valid/ready input
// and emits it one bit per beat on a valid/ready serial output.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic             io_out_bit,
  output logic             io_out_last,
  output logic             io_busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The producer keeps valid and data stable until it is accepted. out_valid is
  // registered state only, so it never depends on out_ready.

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg;
  logic             load;
  logic             beat;
  logic             in_shift;
  logic             cnt_zero;

  assign in_shift = (state_q == SHIFT);
  assign cnt_zero = (cnt_q == '0);
  assign beat     = in_shift & io_out_ready;

  // The reset term keeps ready low while reset is held. Without it ready would
  // follow the IDLE state during reset.
  assign io_in_ready = reset & (~in_shift | (cnt_zero & io_out_ready));
  assign load        = io_in_valid & io_in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = SHIFT;
      cnt_d   = CNT_LOAD;
    end else if (beat) begin
      if (cnt_zero) state_d = IDLE;
      else          cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_reg_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (load),
    .shift_en_i (beat & ~load),
    .data_i     (io_in_bits),
    .q_o        (shreg)
  );

  assign io_out_valid = in_shift;
  assign io_busy      = in_shift;
  assign io_out_last  = in_shift & cnt_zero;
  assign io_out_bit   = in_shift & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer. It drives an MSB-first and an LSB-first instance from shared stimulus.
module tb_piso_serializer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_bits;
  logic       out_ready;

  logic m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy;
  logic l_in_ready, l_out_valid, l_out_bit, l_out_last, l_busy;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (m_in_ready),
    .io_in_bits   (in_bits),
    .io_out_valid (m_out_valid),
    .io_out_ready (out_ready),
    .io_out_bit   (m_out_bit),
    .io_out_last  (m_out_last),
    .io_busy      (m_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (l_in_ready),
    .io_in_bits   (in_bits),
    .io_out_valid (l_out_valid),
    .io_out_ready (out_ready),
    .io_out_bit   (l_out_bit),
    .io_out_last  (l_out_last),
    .io_busy      (l_busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // All sampling and driving happens at the falling edge.
  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_bits = 8'hFF; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      checks++;
      if ({m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold: got rdy/vld/bit/last/busy=%b expected 00000",
                 {m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy});
      end
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", m_in_ready, m_out_valid);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    w = 8'hA5;
    in_valid = 1'b1; in_bits = w; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; in_bits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m_out_valid !== 1'b1 || m_out_bit !== w[7-i] || m_out_last !== (i == 7)) begin
        errors++;
        $display("FAIL msb_a5 beat %0d: got vld=%b bit=%b last=%b expected 1 %b %b",
                 i, m_out_valid, m_out_bit, m_out_last, w[7-i], (i == 7));
      end
      @(negedge clock);
    end
    checks++;
    if (m_out_valid !== 1'b0 || m_busy !== 1'b0 || m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL msb_a5_idle: got vld=%b busy=%b rdy=%b expected 0 0 1", m_out_valid, m_busy, m_in_ready);
    end
  endtask

  task automatic test_lsb_first();
    in_valid = 1'b1; in_bits = 8'h01; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; in_bits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (l_out_valid !== 1'b1 || l_busy !== 1'b1 || l_out_bit !== (i == 0) || l_out_last !== (i == 7)) begin
        errors++;
        $display("FAIL lsb_01 beat %0d: got vld=%b busy=%b bit=%b last=%b expected 1 1 %b %b",
                 i, l_out_valid, l_busy, l_out_bit, l_out_last, (i == 0), (i == 7));
      end
      @(negedge clock);
    end
    checks++;
    if (l_busy !== 1'b0 || l_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_busy_drop: got busy=%b vld=%b expected 0 0", l_busy, l_out_valid);
    end
  endtask

  task automatic test_stall();
    logic [7:0] w;
    int idx;
    int k;
    w = 8'hF0;
    idx = 0;
    k = 0;
    in_valid = 1'b1; in_bits = w; out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0; in_bits = 8'h00;
    while (idx < 8 && k < 40) begin
      checks++;
      if (m_out_valid !== 1'b1 || m_out_bit !== w[7-idx] || m_out_last !== (idx == 7)) begin
        errors++;
        $display("FAIL stall cycle %0d idx %0d: got vld=%b bit=%b last=%b expected 1 %b %b",
                 k, idx, m_out_valid, m_out_bit, m_out_last, w[7-idx], (idx == 7));
      end
      out_ready = (k % 3 == 0);
      if (out_ready) idx++;
      k++;
      @(negedge clock);
    end
    checks++;
    if (idx != 8) begin
      errors++;
      $display("FAIL stall_timeout: got %0d beats expected 8", idx);
    end
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got out_valid=%b expected 0 after 8 beats", m_out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    stream = 16'h3CC3;
    in_valid = 1'b1; in_bits = 8'h3C; out_ready = 1'b1;
    @(negedge clock);
    in_bits = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) in_valid = 1'b0;
      checks++;
      if (m_out_valid !== 1'b1 || m_out_bit !== stream[15-i] || m_out_last !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL b2b beat %0d: got vld=%b bit=%b last=%b expected 1 %b %b",
                 i, m_out_valid, m_out_bit, m_out_last, stream[15-i], (i == 7 || i == 15));
      end
      if (i < 8) begin
        checks++;
        if (m_in_ready !== (i == 7)) begin
          errors++;
          $display("FAIL b2b_ready beat %0d: got in_ready=%b expected %b", i, m_in_ready, (i == 7));
        end
      end
      @(negedge clock);
    end
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got out_valid=%b expected 0", m_out_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    in_valid = 1'b1; in_bits = 8'hFF; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; in_bits = 8'h00;
    repeat (3) @(negedge clock);
    checks++;
    if (m_out_valid !== 1'b1 || m_out_bit !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got vld=%b bit=%b expected 1 1", m_out_valid, m_out_bit);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_clear: got rdy/vld/bit/last/busy=%b expected 00000",
               {m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy});
    end
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b1; in_bits = 8'h00;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m_out_valid !== 1'b1 || m_out_bit !== 1'b0 || m_out_last !== (i == 7)) begin
        errors++;
        $display("FAIL post_reset_00 beat %0d: got vld=%b bit=%b last=%b expected 1 0 %b",
                 i, m_out_valid, m_out_bit, m_out_last, (i == 7));
      end
      @(negedge clock);
    end
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_end: got out_valid=%b expected 0", m_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
